// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

    localparam int unsigned MULDIV_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        MUL_RUN,
        DIV_RUN,
        FIXUP,
        DZ
    } state_e;

    typedef enum logic {
        OP_MUL,
        OP_DIV
    } op_kind_e;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Request/result bundle between the core and the multiply/divide sequencer.
// The is_unsigned request bit exists only when MULDIV_UNSIGNED_EN is defined.
interface muldiv_sequencer_if
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wr_data;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
`ifdef MULDIV_UNSIGNED_EN
    logic             is_unsigned;
`endif

    modport master (
        output start_mult, start_div, op_a, op_b, hi_we, lo_we, wr_data,
`ifdef MULDIV_UNSIGNED_EN
        output is_unsigned,
`endif
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b, hi_we, lo_we, wr_data,
`ifdef MULDIV_UNSIGNED_EN
        input  is_unsigned,
`endif
        output busy, done, div_zero, hi, lo
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply or restoring divide on {acc, q}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input  op_kind_e         op,
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   acc_nxt,
    output logic [WIDTH-1:0] q_nxt
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;

    always_comb begin
        sum     = {1'b0, acc[WIDTH-1:0]} + (q[0] ? {1'b0, operand} : '0);
        rem     = {acc[WIDTH-1:0], q[WIDTH-1]};
        acc_nxt = acc;
        q_nxt   = q;
        if (op == OP_MUL) begin
            // Carry out of the add lands in the top of the shifted product.
            acc_nxt = {1'b0, sum[WIDTH:1]};
            q_nxt   = {sum[0], q[WIDTH-1:1]};
        end else begin
            q_nxt   = {q[WIDTH-2:0], 1'b0};
            acc_nxt = rem;
            if (rem >= {1'b0, operand}) begin
                acc_nxt  = rem - {1'b0, operand};
                q_nxt[0] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide unit owning HI/LO; one bit per cycle.
// Define MULDIV_UNSIGNED_EN to add the is_unsigned request bit (multu/divu).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = MULDIV_WIDTH
) (
    input logic               clck,
    input logic               rst_n,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    op_kind_e           op_q, op_d;
    logic [WIDTH:0]     acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   q_q, q_d, q_step;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .op      (op_q),
        .acc     (acc_q),
        .q       (q_q),
        .operand (opb_q),
        .acc_nxt (acc_step),
        .q_nxt   (q_step)
    );

    always_comb begin
`ifdef MULDIV_UNSIGNED_EN
        neg_a = !bus.is_unsigned && bus.op_a[WIDTH-1];
        neg_b = !bus.is_unsigned && bus.op_b[WIDTH-1];
`else
        neg_a = bus.op_a[WIDTH-1];
        neg_b = bus.op_b[WIDTH-1];
`endif
        mag_a = neg_a ? -bus.op_a : bus.op_a;
        mag_b = neg_b ? -bus.op_b : bus.op_b;
        prod  = {acc_q[WIDTH-1:0], q_q};

        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        q_d       = q_q;
        opb_d     = opb_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                // The done cycle still counts as busy: no starts, no mthi/mtlo.
                if (!done_q) begin
                    if (bus.start_mult || (bus.start_div && bus.op_b != '0)) begin
                        op_d      = bus.start_mult ? OP_MUL : OP_DIV;
                        acc_d     = '0;
                        q_d       = mag_a;
                        opb_d     = mag_b;
                        neg_res_d = neg_a ^ neg_b;
                        neg_rem_d = neg_a;
                        cnt_d     = CW'(WIDTH);
                        state_d   = bus.start_mult ? MUL_RUN : DIV_RUN;
                    end else if (bus.start_div) begin
                        state_d = DZ;
                    end else begin
                        if (bus.hi_we) hi_d = bus.wr_data;
                        if (bus.lo_we) lo_d = bus.wr_data;
                    end
                end
            end
            MUL_RUN, DIV_RUN: begin
                acc_d = acc_step;
                q_d   = q_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = FIXUP;
            end
            FIXUP: begin
                if (op_q == OP_MUL) begin
                    if (neg_res_q) prod = -prod;
                    {hi_d, lo_d} = prod;
                end else begin
                    lo_d = neg_res_q ? -q_q : q_q;
                    hi_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            DZ:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= OP_MUL;
            acc_q     <= '0;
            q_q       <= '0;
            opb_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            opb_q     <= opb_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign bus.busy     = (state_q == MUL_RUN) || (state_q == DIV_RUN) ||
                          (state_q == FIXUP) || done_q;
    assign bus.done     = done_q;
    assign bus.div_zero = (state_q == DZ);
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: latency, signed results, div-by-zero, reset, arbitration.
module tb_muldiv_sequencer;
    logic clck;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    muldiv_sequencer_if #(.WIDTH(32)) bus ();

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clck  (clck),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clck = 1'b0;
    always #5 clck = ~clck;

    task automatic tick();
        @(posedge clck);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
    endtask

    // Issue a request; returns after the accepting edge (edge N).
    task automatic issue(input logic mul, input logic div, input logic [31:0] a,
                         input logic [31:0] b);
        bus.op_a       = a;
        bus.op_b       = b;
        bus.start_mult = mul;
        bus.start_div  = div;
        tick();
        idle_inputs();
    endtask

    // Counts edges after edge N until done; done must arrive at edge N+33.
    task automatic wait_done(input string tag, input int already, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo);
        int cycles;
        cycles = already;
        while (bus.done !== 1'b1 && cycles < 40) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'd33);
        check({tag, "_busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        tick();
        check({tag, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int   k;
        logic seen;
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.wr_data = '0;
`ifdef MULDIV_UNSIGNED_EN
        bus.is_unsigned = 1'b0;
`endif
        idle_inputs();
        #12;
        rst_n = 1'b1;
        tick();

        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);

        // 7 * -3 = -21
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        check("mul_busy_start", {31'd0, bus.busy}, 32'd1);
        wait_done("mul_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // -7 / 2 = -3 rem -1
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_neg", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // Divide by zero leaves HI/LO untouched
        bus.hi_we   = 1'b1;
        bus.wr_data = 32'h0000_1234;
        tick();
        idle_inputs();
        check("mthi", bus.hi, 32'h0000_1234);
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        check("dz_pulse", {31'd0, bus.div_zero}, 32'd1);
        check("dz_busy", {31'd0, bus.busy}, 32'd0);
        check("dz_done", {31'd0, bus.done}, 32'd0);
        tick();
        check("dz_pulse_end", {31'd0, bus.div_zero}, 32'd0);
        check("dz_busy2", {31'd0, bus.busy}, 32'd0);
        check("dz_done2", {31'd0, bus.done}, 32'd0);
        check("dz_hi_kept", bus.hi, 32'h0000_1234);
        check("dz_lo_kept", bus.lo, 32'hFFFF_FFFD);

        // Extremes
        issue(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
        wait_done("mul_min", 0, 32'h4000_0000, 32'h0000_0000);
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", 0, 32'h0000_0000, 32'h8000_0000);

        // Both starts: multiply wins (6*3=18; divide would give 2)
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        wait_done("arb_both", 0, 32'h0000_0000, 32'h0000_0012);

        // Reset during iteration 10 of a multiply
        issue(1'b1, 1'b0, 32'd9, 32'd9);
        for (int i = 0; i < 10; i++) tick();
        rst_n = 1'b0;
        #1;
        check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        check("rstmid_hi", bus.hi, 32'd0);
        check("rstmid_lo", bus.lo, 32'd0);
        #3;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        check("rstmid_no_done", {31'd0, seen}, 32'd0);

        // Start and mtlo/mthi during busy are ignored
        issue(1'b1, 1'b0, 32'd5, 32'd4);
        for (k = 1; k < 5; k++) tick();
        bus.start_div = 1'b1;
        bus.op_a      = 32'd100;
        bus.op_b      = 32'd7;
        bus.lo_we     = 1'b1;
        bus.hi_we     = 1'b1;
        bus.wr_data   = 32'h0000_DEAD;
        tick();
        idle_inputs();
        check("busy_lo_hold", bus.lo, 32'd0);
        wait_done("busy_ignore", 5, 32'h0000_0000, 32'h0000_0014);
        tick();
        check("no_queued_op", {31'd0, bus.busy}, 32'd0);

        // mtlo while idle
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'h0000_ABCD;
        tick();
        idle_inputs();
        check("mtlo_idle", bus.lo, 32'h0000_ABCD);
        check("mtlo_hi_kept", bus.hi, 32'h0000_0000);

        // mthi and mtlo together
        bus.hi_we   = 1'b1;
        bus.lo_we   = 1'b1;
        bus.wr_data = 32'h5555_AAAA;
        tick();
        idle_inputs();
        check("mthilo_hi", bus.hi, 32'h5555_AAAA);
        check("mthilo_lo", bus.lo, 32'h5555_AAAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
